load_ext_ctrl: RTL
==================

LOAD_EXT_CTRL -- requirements
Module: load_ext_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width of addr and mem_addr.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: start  input  1  load request, sampled only in IDLE.
REQ-005 Port: op  input  3  load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101-111 illegal.
REQ-006 Port: addr  input  ADDR_W  byte address of the load, sampled with start.
REQ-007 Port: busy  output  1  high in every state except IDLE.
REQ-008 Port: done  output  1  one-cycle completion pulse.
REQ-009 Port: err  output  1  high only together with done; flags a misaligned address or illegal op.
REQ-010 Port: rdata  output  32  extended load result, registered, held until the next non-error done.
REQ-011 Port: mem_req  output  1  memory read request, held until acknowledged.
REQ-012 Port: mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}, stable while mem_req is high.
REQ-013 Port: mem_ack  input  1  memory read acknowledge; mem_rdata is valid in the same cycle.
REQ-014 Port: mem_rdata  input  32  memory read word, little-endian byte lanes.

Function
REQ-015 States SHALL be IDLE, REQ and DONE.
REQ-016 IDLE with start=1, legal op and aligned addr: latch op, addr[1:0] and mem_addr; go to REQ.
REQ-017 IDLE with start=1 and either an illegal op, LW with addr[1:0]!=0, or LH/LHU with addr[0]!=0: go directly to DONE with err=1; mem_req never asserted; rdata unchanged.
REQ-018 REQ: mem_req=1; stay while mem_ack=0; when mem_ack=1, capture the extended result into rdata and go to DONE.
REQ-019 DONE: done=1 for exactly one cycle, err per REQ-017 (else 0); return to IDLE unconditionally.
REQ-020 Latency: start accepted at edge N gives mem_req=1 from N+1; ack sampled at edge M gives done=1 during the cycle after M; the minimum for an aligned load is done in the cycle after N+1. The error path gives done in the cycle after N.
REQ-021 Lane select: byte = mem_rdata[8*a+7:8*a] with a=addr[1:0]; half = mem_rdata[15:0] if addr[1]=0, else [31:16].
REQ-022 Extension: LB and LH sign-extend to 32 bits; LBU and LHU zero-extend; LW passes the word unchanged.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 mem_ack outside REQ SHALL be ignored.
REQ-025 op and addr changes after acceptance SHALL NOT affect the in-flight load.
REQ-026 Back-to-back: start may be accepted in the IDLE cycle immediately after DONE.

Reset
REQ-027 rst=1 asynchronously forces IDLE: busy=0, done=0, err=0, mem_req=0, mem_addr=0, rdata=0.
REQ-028 rst asserted in REQ or DONE SHALL abort the load, with no done pulse and no rdata update; the memory side tolerates a dropped mem_req.
REQ-029 After rst deasserts, the first rising edge is handled as IDLE.

Structure
REQ-030 Shared package load_pkg SHALL hold the op encodings (OP_LW..OP_LBU) and the state encoding.
REQ-031 Extension SHALL be done in one sub-module ext_unit: parameter WIDTH, inputs a[WIDTH-1:0] and sign, output 32 bits; instantiated for WIDTH=8 and WIDTH=16.
REQ-032 No other sub-modules; the FSM, lane mux and rdata register are local.

Verification
REQ-033 LB, addr=0x10000003, mem_rdata=0x80FF7F01, ack in the first REQ cycle -> rdata=0xFFFFFF80, err=0, done in the second cycle after acceptance.
REQ-034 LBU, addr=0x10000000, mem_rdata=0x80FF7FF1 -> rdata=0x000000F1; LB at addr=0x10000001 with the same data -> rdata=0x0000007F.
REQ-035 LH, addr=0x10000002, mem_rdata=0x80011234 -> rdata=0xFFFF8001; LHU with the same inputs -> rdata=0x00008001; mem_addr=0x10000000 in both.
REQ-036 Misaligned and illegal cases:
- LW, addr=0x10000006 -> done=1, err=1 in the cycle after start; mem_req stays 0; rdata keeps its prior value.
- LH, addr=0x10000001 -> same response.
- op=111 -> same response.
REQ-037 LW, addr=0x10000004, mem_ack delayed 3 cycles:
- mem_req stays high and mem_addr stays stable throughout.
- A second start pulse during busy is ignored.
- mem_rdata=0xDEADBEEF -> rdata=0xDEADBEEF.
- Exactly one done pulse.
REQ-038 rst pulsed mid-REQ -> in the same cycle mem_req=0, busy=0, rdata=0; no done afterwards; a new LB after release completes normally.

Source files
------------

// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared op encodings, FSM states and fault check for load_ext_ctrl
package load_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when the request must be rejected without touching memory.
  function automatic logic load_fault(input logic [2:0] op, input logic [1:0] lsb);
    case (op)
      OP_LW:          return lsb != 2'b00;
      OP_LH, OP_LHU:  return lsb[0];
      OP_LB, OP_LBU:  return 1'b0;
      default:        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ext_unit.sv
// rtl/ext_unit.sv - sign/zero extension of a WIDTH-bit value to 32 bits
module ext_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             sign,
  output logic [31:0]      y
);

  assign y = {{(32-WIDTH){sign & a[WIDTH-1]}}, a};

endmodule

// File: rtl/load_ext_ctrl.sv
// rtl/load_ext_ctrl.sv - single-outstanding load controller: alignment check, memory read, lane select, extension
module load_ext_ctrl
  import load_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q;
  logic [2:0]        op_q;
  logic [1:0]        lane_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       rdata_q;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] byte_ext;
  logic [31:0] half_ext;
  logic [31:0] load_data_d;

  assign byte_lane = mem_rdata[{lane_q, 3'b000} +: 8];
  assign half_lane = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  ext_unit #(.WIDTH(8)) u_ext_byte (
    .a    (byte_lane),
    .sign (op_q == OP_LB),
    .y    (byte_ext)
  );

  ext_unit #(.WIDTH(16)) u_ext_half (
    .a    (half_lane),
    .sign (op_q == OP_LH),
    .y    (half_ext)
  );

  always_comb begin
    load_data_d = mem_rdata;
    case (op_q)
      OP_LB, OP_LBU: load_data_d = byte_ext;
      OP_LH, OP_LHU: load_data_d = half_ext;
      default:       load_data_d = mem_rdata;
    endcase
  end

  // All outputs are registered and set on entry to the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_LW;
      lane_q     <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rdata_q    <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (load_fault(op, addr[1:0])) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q    <= ST_REQ;
              mem_req_q  <= 1'b1;
              op_q       <= op;
              lane_q     <= addr[1:0];
              mem_addr_q <= {addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_q   <= ST_DONE;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            rdata_q   <= load_data_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          err_q     <= 1'b0;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule
